reg_loader: RTL and testbench
=============================

# reg_loader

Write-side front end for the 4 x 512-bit vector register file. Accepts a load command naming a destination register, collects sixteen 32-bit beats over a valid/ready stream and assembles them into one 512-bit word. It then issues a single-cycle write (select, data, enable) on the register file's write port. The block sits between the memory/bus fabric and the register file and is the only agent that drives that write port.

## Interface
- DATA_W, 512, register width; must be a multiple of BEAT_W
- BEAT_W, 32, stream beat width
- NUM_REGS, 4, number of registers implemented behind the write port
- SEL_W, 3, register select width
- clk  input  1  sole clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  load command strobe; sampled only in IDLE
- dest_sel  input  SEL_W  destination register, sampled with start
- s_valid  input  1  beat valid
- s_data  input  BEAT_W  beat payload
- s_ready  output  1  beat accepted when s_valid && s_ready
- busy  output  1  high in every state except IDLE
- sel_reg_write  output  SEL_W  register file write select
- wr_data  output  DATA_W  register file write data
- reg_write_enable  output  1  register file write strobe, one cycle per load
- done  output  1  one-cycle pulse, coincident with reg_write_enable
- err  output  1  one-cycle pulse on rejected command or failed check

## Operation
- BEATS = DATA_W/BEAT_W = 16; beat counter is 4 bits and wraps only via state exit, never mid-load.
- States: IDLE, COLLECT, WRITE (plus CHECK when checksum enabled).
- IDLE: s_ready=0, busy=0. On start:
  - If dest_sel >= NUM_REGS: err pulses next cycle and the block stays in IDLE.
  - Otherwise latch dest_sel, clear the beat counter and go to COLLECT.
- COLLECT: s_ready=1. An accepted beat k (k = 0..15) is written to wr_data bits [k*BEAT_W +: BEAT_W], so beat 0 is least significant. After beat 15 is accepted, go to WRITE, or to CHECK with checksum enabled.
- s_valid low in COLLECT: the block holds state with no timeout. s_data is don't-care when s_valid is low.
- WRITE: reg_write_enable=1, done=1, sel_reg_write=latched select, wr_data=assembled word. Next state is IDLE.
- start while busy is ignored, and dest_sel is not re-sampled.
- Outside WRITE: wr_data and sel_reg_write hold their last values and reg_write_enable=0.

## Timing
- All outputs are registered or decoded from the registered state; there is no combinational path from s_valid to s_ready.
- Reset values: s_ready 0, busy 0, reg_write_enable 0, done 0, err 0, sel_reg_write 0, wr_data 0; state IDLE, beat counter 0.
- Latency with s_valid held high: start at edge 0, COLLECT from cycle 1, beats accepted in cycles 1..16, WRITE in cycle 17, IDLE in cycle 18. The register file captures the word at the end of cycle 17.
- Back-to-back: start may be asserted in the cycle the block returns to IDLE; the next load then begins one cycle later.
- Reset mid-load: returns immediately to IDLE. The partial word is discarded and no write is issued.

## Configuration
- REG_LOADER_CHECKSUM_EN defined:
  - After beat 15, enter CHECK with s_ready=1 and accept one extra beat.
  - If that beat equals the XOR of the 16 data beats, go to WRITE.
  - Otherwise pulse err, issue no write, return to IDLE.
  - Nominal latency becomes 18 cycles.
- Undefined: no CHECK state and no XOR accumulator; the block behaves exactly as described in Operation.

## Structure
- Package reg_loader_pkg holds:
  - the state enum
  - the BEATS constant and beat counter width
  - the default DATA_W, BEAT_W, NUM_REGS and SEL_W values shared with the register file
- One sub-module, beat_assembler, holds the beat counter, indexed word register and optional XOR accumulator. It exposes a last_beat flag to the FSM.

## Test plan
- Reset, then start with dest_sel=2 and beats 0x00000000..0x0000000F, s_valid held high -> one reg_write_enable in cycle 17, sel_reg_write=2, wr_data[31:0]=0, wr_data[511:480]=0xF.
- start with dest_sel=5 -> err pulse one cycle later, busy stays 0, no write.
- Same load with s_valid low on every other cycle -> identical wr_data, and WRITE occurs after the 16th accepted beat.
- Assert rst_n low after beat 7, then start a fresh load to register 1 -> no write for the aborted load; the new word arrives intact.
- Repeat start pulses during COLLECT -> ignored; exactly one write, to the originally latched register.
- With REG_LOADER_CHECKSUM_EN: a correct XOR beat gives a write in cycle 18; a corrupted XOR beat gives an err pulse and no reg_write_enable.

Source files
------------

// File: rtl/reg_loader_pkg.sv
// -----------------------------------------------------------------------------
// reg_loader_pkg
// Shared constants and types for the register-file load front end.
//   - default geometry of the 4 x 512-bit vector register file
//   - beats per word and beat counter width
//   - FSM state encoding
// Optional feature macro: REG_LOADER_CHECKSUM_EN adds the CHECK state.
// -----------------------------------------------------------------------------
package reg_loader_pkg;

    localparam int DATA_W_DEF   = 512;  // register width
    localparam int BEAT_W_DEF   = 32;   // stream beat width
    localparam int NUM_REGS_DEF = 4;    // registers behind the write port
    localparam int SEL_W_DEF    = 3;    // register select width

    localparam int BEATS      = DATA_W_DEF / BEAT_W_DEF;
    localparam int BEAT_CNT_W = $clog2(BEATS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2
`ifdef REG_LOADER_CHECKSUM_EN
        ,
        ST_CHECK   = 2'd3
`endif
    } state_e;

endpackage

// File: rtl/reg_loader_if.sv
// -----------------------------------------------------------------------------
// reg_loader_if
// Bundles the load command, the beat stream and the register-file write port.
//   master : fabric side   - drives start/dest_sel/s_valid/s_data
//   slave  : reg_loader    - drives s_ready/busy/write port/done/err
// -----------------------------------------------------------------------------
interface reg_loader_if
    import reg_loader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int BEAT_W = BEAT_W_DEF,
    parameter int SEL_W  = SEL_W_DEF
);

    logic              start;
    logic [SEL_W-1:0]  dest_sel;
    logic              s_valid;
    logic [BEAT_W-1:0] s_data;
    logic              s_ready;
    logic              busy;
    logic [SEL_W-1:0]  sel_reg_write;
    logic [DATA_W-1:0] wr_data;
    logic              reg_write_enable;
    logic              done;
    logic              err;

    modport master (
        output start, dest_sel, s_valid, s_data,
        input  s_ready, busy, sel_reg_write, wr_data, reg_write_enable, done, err
    );

    modport slave (
        input  start, dest_sel, s_valid, s_data,
        output s_ready, busy, sel_reg_write, wr_data, reg_write_enable, done, err
    );

endinterface

// File: rtl/reg_loader_beat_assembler.sv
// -----------------------------------------------------------------------------
// beat_assembler
// Beat counter plus indexed word register; beat k lands in bits
// [k*BEAT_W +: BEAT_W]. With REG_LOADER_CHECKSUM_EN a running XOR of the
// data beats is kept and compared against the beat currently on data.
// Ports:
//   clk, rst_n   clock / async active-low reset
//   clear        new load accepted: restart counter (and XOR)
//   accept       data beat accepted in COLLECT
//   data         beat payload
//   word         assembled word (drives the write data bus)
//   last_beat    counter points at the final beat slot
//   checksum_ok  data equals XOR of the collected beats (checksum build only)
// -----------------------------------------------------------------------------
module beat_assembler
    import reg_loader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int BEAT_W = BEAT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              accept,
    input  logic [BEAT_W-1:0] data,
    output logic [DATA_W-1:0] word,
    output logic              last_beat
`ifdef REG_LOADER_CHECKSUM_EN
    ,
    output logic              checksum_ok
`endif
);

    logic [BEAT_CNT_W-1:0] cnt;

    // NOTE: the word register is wide but still reset: it is the visible
    // write-data bus and must read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            word <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (accept) begin
            word[int'(cnt)*BEAT_W +: BEAT_W] <= data;
            // Wraps 15 -> 0 exactly on the last beat, i.e. on state exit.
            cnt <= cnt + BEAT_CNT_W'(1);
        end
    end

    assign last_beat = (cnt == BEAT_CNT_W'(BEATS - 1));

`ifdef REG_LOADER_CHECKSUM_EN
    logic [BEAT_W-1:0] acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (accept) begin
            acc <= acc ^ data;
        end
    end

    assign checksum_ok = (data == acc);
`endif

endmodule

// File: rtl/reg_loader.sv
// -----------------------------------------------------------------------------
// reg_loader
// Write-side front end of the vector register file. A load command names a
// destination register; sixteen 32-bit beats are collected into one 512-bit
// word, then a single-cycle write is issued on the register-file write port.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   bus         reg_loader_if.slave: command, beat stream, write port,
//               busy/done/err status
// Optional feature macro: REG_LOADER_CHECKSUM_EN - after the 16 data beats
// one extra beat must equal their XOR, otherwise err pulses and no write.
// All outputs are registered or decoded from the state register; s_ready
// has no combinational dependence on s_valid.
// -----------------------------------------------------------------------------
module reg_loader
    import reg_loader_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int BEAT_W   = BEAT_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int SEL_W    = SEL_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    reg_loader_if.slave bus
);

    state_e            state;
    state_e            state_next;
    logic [SEL_W-1:0]  sel_q;
    logic              err_q;
    logic              err_next;
    logic              clear;
    logic              beat_accept;
    logic              last_beat;
    logic [DATA_W-1:0] word;
`ifdef REG_LOADER_CHECKSUM_EN
    logic              checksum_ok;
`endif

    beat_assembler #(
        .DATA_W (DATA_W),
        .BEAT_W (BEAT_W)
    ) u_beat_assembler (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .accept      (beat_accept),
        .data        (bus.s_data),
        .word        (word),
        .last_beat   (last_beat)
`ifdef REG_LOADER_CHECKSUM_EN
        ,
        .checksum_ok (checksum_ok)
`endif
    );

    // NOTE: every signal driven here gets a default first, so no path
    // through the case leaves one unassigned and infers a latch.
    always_comb begin
        state_next  = state;
        err_next    = 1'b0;
        clear       = 1'b0;
        beat_accept = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (int'(bus.dest_sel) < NUM_REGS) begin
                        clear      = 1'b1;
                        state_next = ST_COLLECT;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ST_COLLECT: begin
                if (bus.s_valid) begin
                    beat_accept = 1'b1;
`ifdef REG_LOADER_CHECKSUM_EN
                    if (last_beat) state_next = ST_CHECK;
`else
                    if (last_beat) state_next = ST_WRITE;
`endif
                end
            end
`ifdef REG_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (bus.s_valid) begin
                    if (checksum_ok) begin
                        state_next = ST_WRITE;
                    end else begin
                        err_next   = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
`endif
            ST_WRITE: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            sel_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_next;
            err_q <= err_next;
            // dest_sel is captured only when a load is accepted, so starts
            // seen while busy can never retarget the write.
            if (clear) sel_q <= bus.dest_sel;
        end
    end

`ifdef REG_LOADER_CHECKSUM_EN
    assign bus.s_ready = (state == ST_COLLECT) || (state == ST_CHECK);
`else
    assign bus.s_ready = (state == ST_COLLECT);
`endif
    assign bus.busy             = (state != ST_IDLE);
    assign bus.reg_write_enable = (state == ST_WRITE);
    assign bus.done             = (state == ST_WRITE);
    assign bus.err              = err_q;
    assign bus.sel_reg_write    = sel_q;
    assign bus.wr_data          = word;

endmodule

// File: tb/tb_reg_loader.sv
// -----------------------------------------------------------------------------
// tb_reg_loader
// Directed bench for reg_loader. Inputs change 1 ns after the rising edge and
// outputs are sampled at that same point, away from the active edge. A monitor
// counts register-file writes seen on rising edges.
// Build with +define+REG_LOADER_CHECKSUM_EN to exercise the checksum variant.
// -----------------------------------------------------------------------------
module tb_reg_loader;

    localparam int DATA_W = 512;
    localparam int BEAT_W = 32;
    localparam int SEL_W  = 3;
`ifdef REG_LOADER_CHECKSUM_EN
    localparam int EXTRA  = 1;
`else
    localparam int EXTRA  = 0;
`endif

    logic clk;
    logic rst_n;

    reg_loader_if #(.DATA_W(DATA_W), .BEAT_W(BEAT_W), .SEL_W(SEL_W)) bus ();

    reg_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int write_count = 0;

    always @(posedge clk) begin
        if (bus.reg_write_enable === 1'b1) write_count <= write_count + 1;
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] ramp(input logic [31:0] base);
        logic [511:0] w;
        for (int k = 0; k < 16; k++) w[k*32 +: 32] = base + 32'(k);
        return w;
    endfunction

    function automatic logic [31:0] ramp_xor(input logic [31:0] base);
        logic [31:0] x;
        x = '0;
        for (int k = 0; k < 16; k++) x = x ^ (base + 32'(k));
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a load and stream 16 ramp beats. gaps: s_valid low every other
    // cycle (starting low). spam: start held high with another select while
    // busy. bad_sum: corrupt the checksum beat (checksum build only).
    // Returns with the DUT one cycle past the final beat; n_edges counts
    // rising edges from the start edge onward.
    task automatic run_load(input logic [2:0] sel, input logic [31:0] base,
                            input bit gaps, input bit spam, input bit bad_sum,
                            output int n_edges);
        int  k;
        int  guard;
        bit  idle_phase;
        bus.start    = 1'b1;
        bus.dest_sel = sel;
        tick();
        n_edges      = 1;
        bus.start    = 1'b0;
        bus.dest_sel = 3'd0;
        check("collect_s_ready", 512'(bus.s_ready), 512'(1));
        check("collect_err_low", 512'(bus.err), 512'(0));
        k          = 0;
        guard      = 0;
        idle_phase = gaps;
        while (k < 16 && guard < 100) begin
            if (spam) begin
                bus.start    = 1'b1;
                bus.dest_sel = sel ^ 3'd1;
            end
            if (idle_phase) begin
                bus.s_valid = 1'b0;
                bus.s_data  = 32'hDEAD_BEEF;
            end else begin
                bus.s_valid = 1'b1;
                bus.s_data  = base + 32'(k);
            end
            tick();
            n_edges++;
            if (!idle_phase) k++;
            if (gaps) idle_phase = !idle_phase;
            guard++;
        end
        if (guard >= 100) check("load_timeout", 512'(guard), 512'(0));
        bus.start   = 1'b0;
        bus.s_valid = 1'b0;
`ifdef REG_LOADER_CHECKSUM_EN
        bus.s_valid = 1'b1;
        bus.s_data  = bad_sum ? (ramp_xor(base) ^ 32'h0000_0100) : ramp_xor(base);
        tick();
        n_edges++;
        bus.s_valid = 1'b0;
`else
        if (bad_sum) check("bad_sum_unsupported", 512'(1), 512'(0));
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w0;
        int n;

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dest_sel = 3'd0;
        bus.s_valid  = 1'b0;
        bus.s_data   = 32'd0;
        tick();
        tick();

        // Reset state.
        check("rst_s_ready", 512'(bus.s_ready), 512'(0));
        check("rst_busy", 512'(bus.busy), 512'(0));
        check("rst_we", 512'(bus.reg_write_enable), 512'(0));
        check("rst_done", 512'(bus.done), 512'(0));
        check("rst_err", 512'(bus.err), 512'(0));
        check("rst_sel", 512'(bus.sel_reg_write), 512'(0));
        check("rst_wr_data", bus.wr_data, 512'(0));
        rst_n = 1'b1;
        tick();

        // Basic load to register 2, beats 0..15, s_valid held high.
        w0 = write_count;
        run_load(3'd2, 32'h0, 1'b0, 1'b0, 1'b0, n);
        check("t1_edges", 512'(n), 512'(17 + EXTRA));
        check("t1_no_early_write", 512'(write_count), 512'(w0));
        check("t1_we", 512'(bus.reg_write_enable), 512'(1));
        check("t1_done", 512'(bus.done), 512'(1));
        check("t1_busy", 512'(bus.busy), 512'(1));
        check("t1_s_ready", 512'(bus.s_ready), 512'(0));
        check("t1_sel", 512'(bus.sel_reg_write), 512'(2));
        check("t1_word", bus.wr_data, ramp(32'h0));
        check("t1_low_beat", 512'(bus.wr_data[31:0]), 512'(0));
        check("t1_high_beat", 512'(bus.wr_data[511:480]), 512'(32'hF));
        tick();
        check("t1_one_write", 512'(write_count), 512'(w0 + 1));
        check("t1_idle_we", 512'(bus.reg_write_enable), 512'(0));
        check("t1_idle_busy", 512'(bus.busy), 512'(0));
        check("t1_hold_word", bus.wr_data, ramp(32'h0));
        check("t1_hold_sel", 512'(bus.sel_reg_write), 512'(2));

        // Out-of-range selects: 5 and the boundary value 4.
        w0 = write_count;
        bus.start    = 1'b1;
        bus.dest_sel = 3'd5;
        tick();
        bus.start = 1'b0;
        check("t2_err_pulse", 512'(bus.err), 512'(1));
        check("t2_busy", 512'(bus.busy), 512'(0));
        check("t2_s_ready", 512'(bus.s_ready), 512'(0));
        tick();
        check("t2_err_clear", 512'(bus.err), 512'(0));
        check("t2_still_idle", 512'(bus.busy), 512'(0));
        bus.start    = 1'b1;
        bus.dest_sel = 3'd4;
        tick();
        bus.start = 1'b0;
        check("t2_sel4_err", 512'(bus.err), 512'(1));
        check("t2_sel4_busy", 512'(bus.busy), 512'(0));
        tick();
        check("t2_no_write", 512'(write_count), 512'(w0));
        check("t2_sel_kept", 512'(bus.sel_reg_write), 512'(2));

        // Same load with s_valid low every other cycle.
        w0 = write_count;
        run_load(3'd2, 32'h0, 1'b1, 1'b0, 1'b0, n);
        check("t3_edges", 512'(n), 512'(33 + EXTRA));
        check("t3_no_early_write", 512'(write_count), 512'(w0));
        check("t3_we", 512'(bus.reg_write_enable), 512'(1));
        check("t3_word", bus.wr_data, ramp(32'h0));
        tick();
        check("t3_one_write", 512'(write_count), 512'(w0 + 1));

        // Reset after beat 7 of a load to register 3, then a fresh load to 1.
        w0 = write_count;
        bus.start    = 1'b1;
        bus.dest_sel = 3'd3;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 32'h200 + 32'(k);
            tick();
        end
        bus.s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t4_abort_busy", 512'(bus.busy), 512'(0));
        check("t4_abort_s_ready", 512'(bus.s_ready), 512'(0));
        check("t4_abort_word", bus.wr_data, 512'(0));
        check("t4_abort_sel", 512'(bus.sel_reg_write), 512'(0));
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("t4_no_write", 512'(write_count), 512'(w0));
        run_load(3'd1, 32'h100, 1'b0, 1'b0, 1'b0, n);
        check("t4_we", 512'(bus.reg_write_enable), 512'(1));
        check("t4_sel", 512'(bus.sel_reg_write), 512'(1));
        check("t4_word", bus.wr_data, ramp(32'h100));
        tick();
        check("t4_one_write", 512'(write_count), 512'(w0 + 1));

        // Start pulses while busy are ignored; then a back-to-back load.
        w0 = write_count;
        run_load(3'd3, 32'hA5A5_0000, 1'b0, 1'b1, 1'b0, n);
        check("t5_edges", 512'(n), 512'(17 + EXTRA));
        check("t5_we", 512'(bus.reg_write_enable), 512'(1));
        check("t5_sel", 512'(bus.sel_reg_write), 512'(3));
        check("t5_word", bus.wr_data, ramp(32'hA5A5_0000));
        tick();
        check("t5_idle", 512'(bus.busy), 512'(0));
        run_load(3'd0, 32'h5555_0010, 1'b0, 1'b0, 1'b0, n);
        check("t6_b2b_we", 512'(bus.reg_write_enable), 512'(1));
        check("t6_b2b_sel", 512'(bus.sel_reg_write), 512'(0));
        check("t6_b2b_word", bus.wr_data, ramp(32'h5555_0010));
        tick();
        tick();
        check("t5_t6_writes", 512'(write_count), 512'(w0 + 2));

`ifdef REG_LOADER_CHECKSUM_EN
        // Corrupted checksum beat: err pulse, no write, back in IDLE.
        w0 = write_count;
        run_load(3'd1, 32'h0000_7000, 1'b0, 1'b0, 1'b1, n);
        check("t7_bad_err", 512'(bus.err), 512'(1));
        check("t7_bad_we", 512'(bus.reg_write_enable), 512'(0));
        check("t7_bad_busy", 512'(bus.busy), 512'(0));
        tick();
        check("t7_err_clear", 512'(bus.err), 512'(0));
        check("t7_no_write", 512'(write_count), 512'(w0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
